// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's run-control, instruction-memory, ALU and host
// register-file signals. The sequencer uses the master view; the
// surrounding system (memory, ALU, host) uses the slave view.
interface alu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            busy;
  logic            done;
  logic            pc_ovf;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [2:0]      alu_opcode;
  logic [11:0]     alu_op1;
  logic [11:0]     alu_op2;
  logic [11:0]     alu_result;
  logic            cfg_we;
  logic [2:0]      cfg_addr;
  logic [11:0]     cfg_wdata;
  logic [11:0]     cfg_rdata;

  modport master (
    input  start, start_pc, imem_data, alu_result, cfg_we, cfg_addr, cfg_wdata,
    output busy, done, pc_ovf, imem_addr, alu_opcode, alu_op1, alu_op2, cfg_rdata
  );

  modport slave (
    output start, start_pc, imem_data, alu_result, cfg_we, cfg_addr, cfg_wdata,
    input  busy, done, pc_ovf, imem_addr, alu_opcode, alu_op1, alu_op2, cfg_rdata
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for a shared 12-bit ALU. Fetches 16-bit
// instructions, reads operands from an 8x12 register file, drives the ALU
// during EXEC and writes the latched result back in WB. Outputs are
// registered and set on the transition into the state that shows them.
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  alu_sequencer_if.master     seq_io
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [11:0]     res_q;
  logic [11:0]     regs_q [8];
  logic            busy_q;
  logic            done_q;
  logic            pc_ovf_q;
  logic [2:0]      alu_opcode_q;
  logic [11:0]     alu_op1_q;
  logic [11:0]     alu_op2_q;

  logic [PC_W-1:0] pc_inc_d;
  logic            pc_last_d;
  logic [2:0]      dec_op_d;
  logic [2:0]      dec_rs1_d;
  logic [2:0]      dec_rs2_d;
  logic            dec_halt_d;
  logic            unused_ir_s;

  // Decode the incoming instruction word and the next program counter.
  always_comb begin
    pc_inc_d   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    pc_last_d  = &pc_q;
    dec_op_d   = seq_io.imem_data[15:13];
    dec_rs1_d  = seq_io.imem_data[9:7];
    dec_rs2_d  = seq_io.imem_data[6:4];
    dec_halt_d = (seq_io.imem_data[15:13] == 3'b000) && seq_io.imem_data[0];
  end

  // Only opcode and rd of the held instruction are needed after decode.
  assign unused_ir_s = ^ir_q[9:0];

  // Sequencer FSM, register file and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= {PC_W{1'b0}};
      ir_q         <= 16'h0000;
      res_q        <= 12'h000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pc_ovf_q     <= 1'b0;
      alu_opcode_q <= 3'b000;
      alu_op1_q    <= 12'h000;
      alu_op2_q    <= 12'h000;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 12'h000;
      end
    end else begin
      // ALU drive and done are single-state outputs; cleared unless set below.
      done_q       <= 1'b0;
      alu_opcode_q <= 3'b000;
      alu_op1_q    <= 12'h000;
      alu_op2_q    <= 12'h000;
      case (state_q)
        ST_IDLE: begin
          if (seq_io.cfg_we) begin
            regs_q[seq_io.cfg_addr] <= seq_io.cfg_wdata;
          end
          if (seq_io.start) begin
            pc_q     <= seq_io.start_pc;
            pc_ovf_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_FETCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_q <= seq_io.imem_data;
          if (dec_halt_d) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            // Operands are read here, after any prior WB, so no hazard exists.
            alu_opcode_q <= dec_op_d;
            alu_op1_q    <= regs_q[dec_rs1_d];
            alu_op2_q    <= regs_q[dec_rs2_d];
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= seq_io.alu_result;
          state_q <= ST_WB;
        end
        ST_WB: begin
          if (ir_q[15:13] != 3'b000) begin
            regs_q[ir_q[12:10]] <= res_q;
          end
          pc_q <= pc_inc_d;
          if (pc_last_d) begin
            pc_ovf_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= ST_FIN;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign seq_io.busy       = busy_q;
  assign seq_io.done       = done_q;
  assign seq_io.pc_ovf     = pc_ovf_q;
  assign seq_io.imem_addr  = pc_q;
  assign seq_io.alu_opcode = alu_opcode_q;
  assign seq_io.alu_op1    = alu_op1_q;
  assign seq_io.alu_op2    = alu_op2_q;
  assign seq_io.cfg_rdata  = regs_q[seq_io.cfg_addr];

endmodule
